// File: rtl/trace_cntrl_mul_pipe.sv
// Pipelined multiplier for the trace controller datapath.
// Stage 1 captures operands, stage 2 holds the full product, and any further stages delay the selected slice.
module trace_cntrl_mul_pipe #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int P_WIDTH = 32,
  parameter int LATENCY = 6,
  parameter bit SIGNED  = 1'b1,
  parameter int P_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] p,
  output logic               busy
);

  localparam int FULL_W = A_WIDTH + B_WIDTH;
  localparam int EXT_W  = FULL_W + P_WIDTH;
  localparam int N_DLY  = LATENCY - 2;

  generate
    if (LATENCY < 2 || LATENCY > 16) begin : g_bad_latency
      $error("trace_cntrl_mul_pipe: LATENCY must be in 2..16");
    end
    if (P_SHIFT < 0 || P_SHIFT > FULL_W - 1) begin : g_bad_shift
      $error("trace_cntrl_mul_pipe: P_SHIFT must be in 0..A_WIDTH+B_WIDTH-1");
    end
  endgenerate

  // Valid/ready contract: there is no ready. in_valid is accepted on every
  // edge with ce=1 and reset=0; out_valid qualifies p and holds while ce=0.

  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic               v1_q, v1_d;
  logic [FULL_W-1:0]  prod_q, prod_d;
  logic               v2_q, v2_d;

  logic [FULL_W-1:0]  a_ext, b_ext, prod_full;
  logic [EXT_W-1:0]   prod_ext;
  logic [P_WIDTH-1:0] slice;
  logic               unused_prod_bits;

  // Extending both operands to FULL_W makes one modular multiply serve both modes.
  always_comb begin
    a_ext     = SIGNED ? {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q} : {{B_WIDTH{1'b0}}, a_q};
    b_ext     = SIGNED ? {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q} : {{A_WIDTH{1'b0}}, b_q};
    prod_full = a_ext * b_ext;
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    v1_d   = v1_q;
    prod_d = prod_q;
    v2_d   = v2_q;
    if (ce) begin
      a_d    = a;
      b_d    = b;
      v1_d   = in_valid;
      prod_d = prod_full;
      v2_d   = v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      v1_q   <= v1_d;
      prod_q <= prod_d;
      v2_q   <= v2_d;
    end
  end

  // Window above the product reads as sign fill (signed) or zero (unsigned).
  always_comb begin
    prod_ext = {{P_WIDTH{SIGNED & prod_q[FULL_W-1]}}, prod_q};
    slice    = prod_ext[P_SHIFT +: P_WIDTH];
  end

  assign unused_prod_bits = ^prod_ext;

  generate
    if (N_DLY < 1) begin : g_no_dly
      assign p         = slice;
      assign out_valid = v2_q;
      assign busy      = v1_q | v2_q;
    end else begin : g_dly
      logic [P_WIDTH-1:0] dly_q [N_DLY];
      logic [P_WIDTH-1:0] dly_d [N_DLY];
      logic [N_DLY-1:0]   dv_q, dv_d;

      always_comb begin
        dly_d = dly_q;
        dv_d  = dv_q;
        if (ce) begin
          dly_d[0] = slice;
          dv_d[0]  = v2_q;
          for (int i = 1; i < N_DLY; i++) begin
            dly_d[i] = dly_q[i-1];
            dv_d[i]  = dv_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < N_DLY; i++) begin
            dly_q[i] <= '0;
          end
          dv_q <= '0;
        end else begin
          dly_q <= dly_d;
          dv_q  <= dv_d;
        end
      end

      assign p         = dly_q[N_DLY-1];
      assign out_valid = dv_q[N_DLY-1];
      assign busy      = v1_q | v2_q | (|dv_q);
    end
  endgenerate

endmodule

// File: tb/tb_trace_cntrl_mul_pipe.sv
// Bench for trace_cntrl_mul_pipe: four parameterisations share clk/reset/ce/in_valid
// and are checked against a due-time scoreboard plus directed scenario expectations.
module tb_trace_cntrl_mul_pipe;

  localparam int LAT  = 6;
  localparam int LAT2 = 2;

  logic        clk;
  logic        reset, ce, in_valid;
  logic [31:0] a_w, b_w;
  logic [15:0] a16;
  logic [7:0]  b8;

  logic        ov_def, bz_def, ov_us, bz_us, ov_s32, bz_s32, ov_l2, bz_l2;
  logic [31:0] p_def, p_us, p_s32;
  logic [23:0] p_l2;

  int total = 0;
  int bad   = 0;

  trace_cntrl_mul_pipe u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a_w), .b(b_w),
    .out_valid(ov_def), .p(p_def), .busy(bz_def));

  trace_cntrl_mul_pipe #(.SIGNED(1'b0), .P_SHIFT(32)) u_us (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a_w), .b(b_w),
    .out_valid(ov_us), .p(p_us), .busy(bz_us));

  trace_cntrl_mul_pipe #(.SIGNED(1'b1), .P_SHIFT(32)) u_s32 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a_w), .b(b_w),
    .out_valid(ov_s32), .p(p_s32), .busy(bz_s32));

  trace_cntrl_mul_pipe #(.A_WIDTH(16), .B_WIDTH(8), .P_WIDTH(24), .LATENCY(LAT2),
                         .SIGNED(1'b1), .P_SHIFT(0)) u_l2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .a(a16), .b(b8),
    .out_valid(ov_l2), .p(p_l2), .busy(bz_l2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each accepted pair is due on the enabled edge LATENCY-1 after the one that sampled it.
  typedef struct { int due; logic [31:0] pd; logic [31:0] pu; logic [31:0] ps; } ent_t;
  typedef struct { int due; logic [23:0] p; } ent2_t;
  ent_t  exp_q[$];
  ent2_t exp2_q[$];
  int    en_cnt = 0;
  logic        exp_ov = 1'b0, exp_bz = 1'b0, exp2_ov = 1'b0, exp2_bz = 1'b0;
  logic [31:0] exp_pd = '0, exp_pu = '0, exp_ps = '0;
  logic [23:0] exp2_p = '0;

  always @(posedge clk) begin
    longint      sp;
    logic [63:0] up;
    int          s2;
    ent_t        e;
    ent2_t       e2;
    if (reset) begin
      exp_q.delete();
      exp2_q.delete();
    end else if (ce) begin
      en_cnt++;
      if (in_valid) begin
        sp    = longint'($signed(a_w)) * longint'($signed(b_w));
        up    = {32'd0, a_w} * {32'd0, b_w};
        e.due = en_cnt + LAT - 1;
        e.pd  = sp[31:0];
        e.ps  = sp[63:32];
        e.pu  = up[63:32];
        exp_q.push_back(e);
        s2     = int'($signed(a16)) * int'($signed(b8));
        e2.due = en_cnt + LAT2 - 1;
        e2.p   = s2[23:0];
        exp2_q.push_back(e2);
      end
      while (exp_q.size() != 0 && exp_q[0].due < en_cnt) void'(exp_q.pop_front());
      while (exp2_q.size() != 0 && exp2_q[0].due < en_cnt) void'(exp2_q.pop_front());
    end
    exp_bz  = exp_q.size() != 0;
    exp2_bz = exp2_q.size() != 0;
    exp_ov  = 1'b0;
    exp2_ov = 1'b0;
    if (exp_q.size() != 0) begin
      if (exp_q[0].due == en_cnt) begin
        exp_ov = 1'b1;
        exp_pd = exp_q[0].pd;
        exp_pu = exp_q[0].pu;
        exp_ps = exp_q[0].ps;
      end
    end
    if (exp2_q.size() != 0) begin
      if (exp2_q[0].due == en_cnt) begin
        exp2_ov = 1'b1;
        exp2_p  = exp2_q[0].p;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic c, input logic v,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [15:0] a2, input logic [7:0] b2);
    reset    = r;
    ce       = c;
    in_valid = v;
    a_w      = av;
    b_w      = bv;
    a16      = a2;
    b8       = b2;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, (k == 0), 1'b1, $urandom, $urandom, 16'($urandom), 8'($urandom));
      total++; if (ov_def !== 1'b0) begin bad++; $display("FAIL reset_ov_def got=%b exp=0", ov_def); end
      total++; if (p_def !== 32'd0) begin bad++; $display("FAIL reset_p_def got=%h exp=0", p_def); end
      total++; if (bz_def !== 1'b0) begin bad++; $display("FAIL reset_busy_def got=%b exp=0", bz_def); end
      total++; if ({ov_us, ov_s32, ov_l2} !== 3'b000) begin bad++; $display("FAIL reset_ov_others got=%b exp=000", {ov_us, ov_s32, ov_l2}); end
      total++; if ({p_us, p_s32} !== 64'd0) begin bad++; $display("FAIL reset_p_wide got=%h exp=0", {p_us, p_s32}); end
      total++; if (p_l2 !== 24'd0) begin bad++; $display("FAIL reset_p_l2 got=%h exp=0", p_l2); end
      total++; if ({bz_us, bz_s32, bz_l2} !== 3'b000) begin bad++; $display("FAIL reset_busy_others got=%b exp=000", {bz_us, bz_s32, bz_l2}); end
    end
  endtask

  task automatic test_single();
    int ov_cnt = 0;
    int bz_cnt = 0;
    drive(1'b0, 1'b1, 1'b1, -32'sd3, 32'sd7, 16'd0, 8'd0);
    for (int i = 1; i <= 10; i++) begin
      if (ov_def) ov_cnt++;
      if (bz_def) bz_cnt++;
      total++; if (ov_def !== (i == LAT)) begin bad++; $display("FAIL single_ov cyc=%0d got=%b exp=%b", i, ov_def, (i == LAT)); end
      total++; if (bz_def !== (i <= LAT)) begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", i, bz_def, (i <= LAT)); end
      if (i == LAT) begin
        total++; if (p_def !== 32'hFFFF_FFEB) begin bad++; $display("FAIL single_p got=%h exp=ffffffeb", p_def); end
      end
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
    end
    total++; if (ov_cnt != 1) begin bad++; $display("FAIL single_ov_count got=%0d exp=1", ov_cnt); end
    total++; if (bz_cnt != LAT) begin bad++; $display("FAIL single_busy_count got=%0d exp=%0d", bz_cnt, LAT); end
  endtask

  task automatic test_back_to_back();
    int n = 1;
    int first = -1;
    int last = -1;
    for (int c = 0; c < 28; c++) begin
      if (c < 20) drive(1'b0, 1'b1, 1'b1, 32'(c + 1), 32'(c + 2), 16'($urandom), 8'($urandom));
      else        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
      total++; if (ov_def !== exp_ov) begin bad++; $display("FAIL b2b_ov cyc=%0d got=%b exp=%b", c, ov_def, exp_ov); end
      total++; if (bz_def !== exp_bz) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", c, bz_def, exp_bz); end
      if (ov_def === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        total++; if (p_def !== 32'(n * (n + 1))) begin bad++; $display("FAIL b2b_p idx=%0d got=%0d exp=%0d", n, p_def, n * (n + 1)); end
        n++;
      end
    end
    total++; if (n != 21) begin bad++; $display("FAIL b2b_count got=%0d exp=20", n - 1); end
    total++; if (last - first != 19) begin bad++; $display("FAIL b2b_contiguous got=%0d exp=19", last - first); end
  endtask

  task automatic test_ce_stall();
    drive(1'b0, 1'b1, 1'b1, 32'd5, 32'd6, 16'd0, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'($urandom), $urandom, $urandom, 16'($urandom), 8'($urandom));
      total++; if (ov_def !== 1'b0) begin bad++; $display("FAIL stall_ov cyc=%0d got=%b exp=0", k, ov_def); end
      total++; if (p_def !== 32'd0) begin bad++; $display("FAIL stall_p cyc=%0d got=%h exp=0", k, p_def); end
      total++; if (bz_def !== 1'b1) begin bad++; $display("FAIL stall_busy cyc=%0d got=%b exp=1", k, bz_def); end
    end
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
      total++; if (ov_def !== (k == 3)) begin bad++; $display("FAIL stall_resume_ov k=%0d got=%b exp=%b", k, ov_def, (k == 3)); end
      if (k == 3) begin
        total++; if (p_def !== 32'd30) begin bad++; $display("FAIL stall_resume_p got=%0d exp=30", p_def); end
      end
    end
  endtask

  task automatic test_wide();
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 8'd0);
    for (int i = 1; i <= LAT; i++) begin
      if (i == LAT) begin
        total++; if (ov_us !== 1'b1 || p_us !== 32'hFFFF_FFFE) begin bad++; $display("FAIL unsigned_shift32 got=%b/%h exp=1/fffffffe", ov_us, p_us); end
        total++; if (ov_s32 !== 1'b1 || p_s32 !== 32'h0) begin bad++; $display("FAIL signed_shift32 got=%b/%h exp=1/00000000", ov_s32, p_s32); end
        total++; if (ov_def !== 1'b1 || p_def !== 32'h1) begin bad++; $display("FAIL signed_shift0 got=%b/%h exp=1/00000001", ov_def, p_def); end
      end else begin
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] av, bv, pe;
    drive(1'b0, 1'b1, 1'b1, $urandom, $urandom, 16'($urandom), 8'($urandom));
    drive(1'b0, 1'b1, 1'b1, $urandom, $urandom, 16'($urandom), 8'($urandom));
    drive(1'b1, 1'b0, 1'b1, $urandom, $urandom, 16'($urandom), 8'($urandom));
    total++; if (ov_def !== 1'b0 || p_def !== 32'd0 || bz_def !== 1'b0) begin bad++; $display("FAIL midreset_clear got=%b/%h/%b exp=0/0/0", ov_def, p_def, bz_def); end
    total++; if (bz_l2 !== 1'b0 || p_l2 !== 24'd0) begin bad++; $display("FAIL midreset_clear_l2 got=%b/%h exp=0/0", bz_l2, p_l2); end
    drive(1'b0, 1'b0, 1'b1, $urandom, $urandom, 16'($urandom), 8'($urandom));
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
      total++; if (ov_def !== 1'b0 || ov_l2 !== 1'b0) begin bad++; $display("FAIL midreset_ghost cyc=%0d got=%b%b exp=00", k, ov_def, ov_l2); end
    end
    av = $urandom;
    bv = $urandom;
    pe = av * bv;
    drive(1'b0, 1'b1, 1'b1, av, bv, 16'd0, 8'd0);
    for (int i = 1; i <= LAT; i++) begin
      total++; if (ov_def !== (i == LAT)) begin bad++; $display("FAIL midreset_new_ov cyc=%0d got=%b exp=%b", i, ov_def, (i == LAT)); end
      if (i == LAT) begin
        total++; if (p_def !== pe) begin bad++; $display("FAIL midreset_new_p got=%h exp=%h", p_def, pe); end
      end
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
    end
  endtask

  task automatic test_l2();
    drive(1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 16'h8000, 8'h80);
    total++; if (ov_l2 !== 1'b0 || bz_l2 !== 1'b1) begin bad++; $display("FAIL l2_edge1 got=%b/%b exp=0/1", ov_l2, bz_l2); end
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
    total++; if (ov_l2 !== 1'b1 || p_l2 !== 24'h40_0000) begin bad++; $display("FAIL l2_result got=%b/%h exp=1/400000", ov_l2, p_l2); end
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 16'd0, 8'd0);
    total++; if (ov_l2 !== 1'b0 || bz_l2 !== 1'b0) begin bad++; $display("FAIL l2_drain got=%b/%b exp=0/0", ov_l2, bz_l2); end
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 7))
        0:       av = 32'h8000_0000;
        1:       av = 32'hFFFF_FFFF;
        default: av = $urandom;
      endcase
      bv = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), 1'($urandom),
            av, bv, 16'($urandom), 8'($urandom));
      total++; if (ov_def !== exp_ov || (exp_ov && p_def !== exp_pd)) begin bad++; $display("FAIL rand_def cyc=%0d got=%b/%h exp=%b/%h", c, ov_def, p_def, exp_ov, exp_pd); end
      total++; if (ov_us !== exp_ov || (exp_ov && p_us !== exp_pu)) begin bad++; $display("FAIL rand_us cyc=%0d got=%b/%h exp=%b/%h", c, ov_us, p_us, exp_ov, exp_pu); end
      total++; if (ov_s32 !== exp_ov || (exp_ov && p_s32 !== exp_ps)) begin bad++; $display("FAIL rand_s32 cyc=%0d got=%b/%h exp=%b/%h", c, ov_s32, p_s32, exp_ov, exp_ps); end
      total++; if (bz_def !== exp_bz || bz_us !== exp_bz) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b%b exp=%b", c, bz_def, bz_us, exp_bz); end
      total++; if (ov_l2 !== exp2_ov || (exp2_ov && p_l2 !== exp2_p)) begin bad++; $display("FAIL rand_l2 cyc=%0d got=%b/%h exp=%b/%h", c, ov_l2, p_l2, exp2_ov, exp2_p); end
      total++; if (bz_l2 !== exp2_bz) begin bad++; $display("FAIL rand_l2_busy cyc=%0d got=%b exp=%b", c, bz_l2, exp2_bz); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    ce       = 1'b0;
    in_valid = 1'b0;
    a_w      = '0;
    b_w      = '0;
    a16      = '0;
    b8       = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_ce_stall();
    test_wide();
    test_reset_mid();
    test_l2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
